// File: rtl/mux_sel_pkg.sv
// Shared constants and helpers for the round-robin mux select controller.
// Holds the FSM state encoding, the mux select codes and the request count.
package mux_sel_pkg;

   // Number of requesters, one per mux input.
   localparam int N_REQ = 4;

   // Mux select codes: {sel0,sel1} value that routes mux input i1..i4.
   localparam logic [1:0] SEL_I1 = 2'b00;
   localparam logic [1:0] SEL_I2 = 2'b01;
   localparam logic [1:0] SEL_I3 = 2'b10;
   localparam logic [1:0] SEL_I4 = 2'b11;

   // Controller states: waiting, granting a burst, settling gap.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_GAP  = 2'b10
   } state_e;

   // Turns a select index into the matching one-hot grant vector.
   function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
      logic [N_REQ-1:0] vec;
      case (idx)
         SEL_I1:  vec = 4'b0001;
         SEL_I2:  vec = 4'b0010;
         SEL_I3:  vec = 4'b0100;
         SEL_I4:  vec = 4'b1000;
         default: vec = 4'b0000;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin winner pick over four request lines.
// Search starts just after the last owner and wraps back to it, so a
// lone requester always wins even when it was the previous owner.
module rr_pick4
   import mux_sel_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       ptr,
   output logic [1:0]       win,
   output logic             any
);

   logic [1:0] cand;

   // Walk ptr+1, ptr+2, ptr+3, ptr (mod 4) and keep the first request found.
   always_comb begin
      win  = ptr;
      any  = 1'b0;
      cand = ptr;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = ptr + 2'(i);
         if (!any && req[cand]) begin
            win = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_select_ctrl.sv
// Registered round-robin select generator feeding the 4:1 mux.
// Grants one requester for a bounded burst, then forces a single
// grant-free cycle so the mux output settles before the next owner.
// Selects hold their last value while nobody owns the mux.
module mux_rr_select_ctrl
   import mux_sel_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic             sel0,
   output logic             sel1,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [1:0]       sel_q, sel_d;

   logic [1:0]       pickWin;
   logic             pickAny;
   logic             burstEnd;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr_q),
      .win (pickWin),
      .any (pickAny)
   );

   // The owner index is sel_q while busy; any end condition closes the burst.
   assign burstEnd = done || !req[sel_q] || (cnt_q == LAST_CNT);

   // Next-state logic: pick a new owner from IDLE/GAP, run or end the burst in BUSY.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      case (state_q)
         ST_BUSY: begin
            if (burstEnd) begin
               state_d = ST_GAP;
               grant_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE, ST_GAP: begin
            if (pickAny) begin
               state_d = ST_BUSY;
               grant_d = onehot4(pickWin);
               sel_d   = pickWin;
               cnt_d   = '0;
               ptr_d   = pickWin;
            end else begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State, pointer, counter and output registers; reset puts priority on req[0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd3;
         cnt_q   <= '0;
         grant_q <= '0;
         sel_q   <= SEL_I1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
      end
   end

   assign grant = grant_q;
   assign sel0  = sel_q[1];
   assign sel1  = sel_q[0];
   assign busy  = |grant_q;

endmodule
